jacobi_feeder: RTL

JACOBI_FEEDER -- requirements
Module: jacobi_feeder

---
 rtl/jacobi_pkg.sv | 19 +
 rtl/jacobi_feeder_if.sv | 16 +
 rtl/feeder_buf.sv | 18 +
 rtl/jacobi_feeder.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/jacobi_pkg.sv
// Shared definitions for the Jacobi solver feeder: FSM encoding, default sizes
// and the WAIT_RES watchdog limit used when JACOBI_FEEDER_TIMEOUT_EN is defined.
package jacobi_pkg;

    localparam int          DW_DEFAULT    = 32;
    localparam int          MAX_N_DEFAULT = 16;
    localparam logic [31:0] WD_LIMIT      = 32'h0010_0000;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_N   = 3'd1,
        SEND_IT  = 3'd2,
        SEND_TH  = 3'd3,
        STREAM   = 3'd4,
        WAIT_RES = 3'd5,
        DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/jacobi_feeder_if.sv
// Coefficient buffer bus: one write port and one synchronous read port
// (rdata is valid the cycle after re is sampled).
interface jacobi_feeder_if #(
    parameter int DW = 32,
    parameter int AW = 8
);
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          re;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;

    modport master (output we, waddr, wdata, re, raddr, input rdata);
    modport slave  (input we, waddr, wdata, re, raddr, output rdata);
endinterface

// File: rtl/feeder_buf.sv
// MAX_N*MAX_N x DW single-clock dual-port RAM; contents are not reset.
module feeder_buf #(
    parameter int MAX_N = 16,
    parameter int DW    = 32
) (
    input logic            clk,
    jacobi_feeder_if.slave bus
);
    localparam int DEPTH = MAX_N * MAX_N;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (bus.we) mem[bus.waddr] <= bus.wdata;
        if (bus.re) bus.rdata <= mem[bus.raddr];
    end

endmodule

// File: rtl/jacobi_feeder.sv
// Feeds one problem (N, iteration limit, threshold, N*N coefficients) into the
// solver and returns its result. Optional watchdog: JACOBI_FEEDER_TIMEOUT_EN.
module jacobi_feeder
    import jacobi_pkg::*;
#(
    parameter int MAX_N = MAX_N_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    n_cfg,
    input  logic [DW-1:0] iter_cfg,
    input  logic [DW-1:0] thresh_cfg,
    input  logic          buf_we,
    input  logic [7:0]    buf_addr,
    input  logic [DW-1:0] buf_wdata,
    output logic          go,
    output logic [DW-1:0] din,
    input  logic          drdy,
    input  logic [DW-1:0] dout,
    output logic [DW-1:0] result,
    output logic          result_valid,
    output logic          busy,
    output logic          err,
    output state_t        state
);
    localparam int DEPTH = MAX_N * MAX_N;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t        state_q, state_n;
    logic [7:0]    n_q;
    logic [DW-1:0] iter_q, thresh_q, result_q;
    logic [15:0]   cnt, nn;
    logic          err_q, err_n, rd_en, start_ok, timeout;

    jacobi_feeder_if #(.DW(DW), .AW(AW)) buf_bus ();

    feeder_buf #(.MAX_N(MAX_N), .DW(DW)) u_buf (
        .clk (clk),
        .bus (buf_bus)
    );

    assign buf_bus.we    = buf_we && (state_q == IDLE) && (int'(buf_addr) < DEPTH);
    assign buf_bus.waddr = AW'(buf_addr);
    assign buf_bus.wdata = buf_wdata;
    assign buf_bus.re    = rd_en;
    assign buf_bus.raddr = AW'(cnt);

    assign nn       = 16'(n_q) * 16'(n_q);
    assign start_ok = start && (n_cfg != 8'd0) && (int'(n_cfg) <= MAX_N);

`ifdef JACOBI_FEEDER_TIMEOUT_EN
    logic [31:0] wd_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 wd_cnt <= 32'd0;
        else if (state_q != WAIT_RES) wd_cnt <= 32'd0;
        else                        wd_cnt <= wd_cnt + 32'd1;
    end

    assign timeout = (state_q == WAIT_RES) && !drdy && (wd_cnt == WD_LIMIT - 32'd1);
`else
    assign timeout = 1'b0;
`endif

    // cnt runs one address ahead of din: address k is read in the cycle before
    // stream word k is shown, starting with address 0 during SEND_TH.
    always_comb begin
        state_n = state_q;
        err_n   = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok)   state_n = SEND_N;
                else if (start) err_n   = 1'b1;
            end
            SEND_N:  state_n = SEND_IT;
            SEND_IT: state_n = SEND_TH;
            SEND_TH: begin
                rd_en   = 1'b1;
                state_n = STREAM;
            end
            STREAM: begin
                if (cnt == nn) state_n = WAIT_RES;
                else           rd_en   = 1'b1;
            end
            WAIT_RES: begin
                if (drdy || timeout) state_n = DONE;
                err_n = timeout;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            n_q      <= 8'd0;
            iter_q   <= '0;
            thresh_q <= '0;
            cnt      <= 16'd0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            err_q   <= err_n;
            if (state_q == IDLE && start_ok) begin
                n_q      <= n_cfg;
                iter_q   <= iter_cfg;
                thresh_q <= thresh_cfg;
            end
            if (state_q == IDLE) cnt <= 16'd0;
            else if (rd_en)      cnt <= cnt + 16'd1;
            if (state_q == WAIT_RES && drdy) result_q <= dout;
            else if (timeout)                result_q <= '1;
        end
    end

    // Solver handshake: go is high only in the cycle din carries N; the solver
    // presents a result by raising drdy with dout valid, accepted only in WAIT_RES.
    always_comb begin
        din = '0;
        case (state_q)
            SEND_N:  din = DW'(n_q);
            SEND_IT: din = iter_q;
            SEND_TH: din = thresh_q;
            STREAM:  din = buf_bus.rdata;
            default: din = '0;
        endcase
    end

    assign go           = (state_q == SEND_N);
    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == DONE);
    assign result       = result_q;
    assign err          = err_q;
    assign state        = state_q;

endmodule
